// File: rtl/id_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_reg_pkg
// Shared pipeline definitions: field widths and the EXE_CMD encodings used
// by the ID/EXE boundary register and the execute stage.
// -----------------------------------------------------------------------------
package id_stage_reg_pkg;

   localparam int DATA_W  = 32;  // PC and register-file operand width
   localparam int SHIFT_W = 12;  // shifter operand field
   localparam int IMM_W   = 24;  // signed branch immediate
   localparam int REG_W   = 4;   // register index
   localparam int CMD_W   = 4;   // ALU command
   localparam int CNT_W   = 16;  // bubble counter

   typedef enum logic [CMD_W-1:0] {
      EXE_NOP = 4'b0000,
      EXE_MOV = 4'b0001,
      EXE_ADD = 4'b0010,
      EXE_ADC = 4'b0011,
      EXE_SUB = 4'b0100,
      EXE_SBC = 4'b0101,
      EXE_AND = 4'b0110,
      EXE_ORR = 4'b0111,
      EXE_EOR = 4'b1000,
      EXE_MVN = 4'b1001
   } exe_cmd_e;

endpackage

// File: rtl/id_stage_reg_pipe_field_reg.sv
// -----------------------------------------------------------------------------
// pipe_field_reg
// One field of a pipeline boundary register.
// Priority: async clear (rst low) > synchronous clear > hold > load.
//   clk    : pipeline clock
//   rst    : asynchronous active-low clear
//   hold   : keep current value
//   clear  : synchronous clear to zero
//   d      : next value
//   q      : registered value
// -----------------------------------------------------------------------------
module pipe_field_reg #(
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              clear,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (clear) begin
         q <= '0;
      end else if (!hold) begin
         q <= d;
      end
   end

endmodule

// File: rtl/id_stage_reg.sv
// -----------------------------------------------------------------------------
// id_stage_reg
// ID -> EXE pipeline register with stall (freeze), kill (flush) and bubble
// insertion for invalid slots, plus a saturating count of bubbles sent to EXE.
//   clk, rst               : clock, asynchronous active-low reset
//   freeze                 : hold every registered output
//   flush                  : kill the instruction being captured (wins over freeze)
//   valid_in               : ID slot holds a real instruction
//   EXE_CMD_in .. C_in     : decoded fields, each registered to its *_out
//   valid_out              : EXE slot holds a real instruction
//   bubble_cnt             : saturating count of bubbles inserted into EXE
// -----------------------------------------------------------------------------
module id_stage_reg
   import id_stage_reg_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic               flush,
   input  logic               valid_in,
   input  logic [CMD_W-1:0]   EXE_CMD_in,
   input  logic               mem_read_in,
   input  logic               mem_write_in,
   input  logic               WB_EN_in,
   input  logic               B_in,
   input  logic               S_in,
   input  logic [DATA_W-1:0]  PC_in,
   input  logic [DATA_W-1:0]  Val_Rn_in,
   input  logic [DATA_W-1:0]  Val_Rm_in,
   input  logic               imm_in,
   input  logic [SHIFT_W-1:0] shift_operand_in,
   input  logic [IMM_W-1:0]   signed_imm_24_in,
   input  logic [REG_W-1:0]   dest_in,
   input  logic [REG_W-1:0]   src1_in,
   input  logic [REG_W-1:0]   src2_in,
   input  logic               C_in,
   output logic               valid_out,
   output logic [CMD_W-1:0]   EXE_CMD_out,
   output logic               mem_read_out,
   output logic               mem_write_out,
   output logic               WB_EN_out,
   output logic               B_out,
   output logic               S_out,
   output logic [DATA_W-1:0]  PC_out,
   output logic [DATA_W-1:0]  Val_Rn_out,
   output logic [DATA_W-1:0]  Val_Rm_out,
   output logic               imm_out,
   output logic [SHIFT_W-1:0] shift_operand_out,
   output logic [IMM_W-1:0]   signed_imm_24_out,
   output logic [REG_W-1:0]   dest_out,
   output logic [REG_W-1:0]   src1_out,
   output logic [REG_W-1:0]   src2_out,
   output logic               C_out,
   output logic [CNT_W-1:0]   bubble_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // Control bits are gated by valid_in so an invalid slot enters EXE as a
   // bubble that cannot write memory, registers or flags. Data fields still
   // load; they are don't-care once valid_out is low.
   logic [CMD_W-1:0] cmd_d;
   logic             bubble_p0;

   assign cmd_d     = valid_in ? EXE_CMD_in : EXE_NOP;
   assign bubble_p0 = flush | (~freeze & ~valid_in);

   // ---- ID/EXE boundary: control fields ----
   pipe_field_reg #(.DATA_W(1))     u_valid (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                             .d(valid_in), .q(valid_out));
   pipe_field_reg #(.DATA_W(CMD_W)) u_cmd   (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                             .d(cmd_d), .q(EXE_CMD_out));
   pipe_field_reg #(.DATA_W(1))     u_mrd   (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                             .d(valid_in & mem_read_in), .q(mem_read_out));
   pipe_field_reg #(.DATA_W(1))     u_mwr   (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                             .d(valid_in & mem_write_in), .q(mem_write_out));
   pipe_field_reg #(.DATA_W(1))     u_wb    (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                             .d(valid_in & WB_EN_in), .q(WB_EN_out));
   pipe_field_reg #(.DATA_W(1))     u_b     (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                             .d(valid_in & B_in), .q(B_out));
   pipe_field_reg #(.DATA_W(1))     u_s     (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                             .d(valid_in & S_in), .q(S_out));

   // ---- ID/EXE boundary: data fields ----
   pipe_field_reg #(.DATA_W(DATA_W))  u_pc   (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                              .d(PC_in), .q(PC_out));
   pipe_field_reg #(.DATA_W(DATA_W))  u_rn   (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                              .d(Val_Rn_in), .q(Val_Rn_out));
   pipe_field_reg #(.DATA_W(DATA_W))  u_rm   (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                              .d(Val_Rm_in), .q(Val_Rm_out));
   pipe_field_reg #(.DATA_W(1))       u_imm  (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                              .d(imm_in), .q(imm_out));
   pipe_field_reg #(.DATA_W(SHIFT_W)) u_sh   (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                              .d(shift_operand_in), .q(shift_operand_out));
   pipe_field_reg #(.DATA_W(IMM_W))   u_si   (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                              .d(signed_imm_24_in), .q(signed_imm_24_out));
   pipe_field_reg #(.DATA_W(REG_W))   u_dst  (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                              .d(dest_in), .q(dest_out));
   pipe_field_reg #(.DATA_W(REG_W))   u_s1   (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                              .d(src1_in), .q(src1_out));
   pipe_field_reg #(.DATA_W(REG_W))   u_s2   (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                              .d(src2_in), .q(src2_out));
   pipe_field_reg #(.DATA_W(1))       u_c    (.clk(clk), .rst(rst), .hold(freeze), .clear(flush),
                                              .d(C_in), .q(C_out));

   // ---- bubble counter: one count per bubble edge, flush+freeze counts once ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bubble_cnt <= '0;
      end else if (bubble_p0) begin
         bubble_cnt <= sat_inc(bubble_cnt);
      end
   end

endmodule

// File: tb/tb_id_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_stage_reg
// Self-checking bench for id_stage_reg: expected register contents are
// produced by a behavioural model when stimulus is applied, queued, and
// compared against the DUT one edge later.
// -----------------------------------------------------------------------------
module tb_id_stage_reg;
   import id_stage_reg_pkg::*;

   logic        clk, rst, freeze, flush, valid_in;
   logic [3:0]  EXE_CMD_in;
   logic        mem_read_in, mem_write_in, WB_EN_in, B_in, S_in;
   logic [31:0] PC_in, Val_Rn_in, Val_Rm_in;
   logic        imm_in;
   logic [11:0] shift_operand_in;
   logic [23:0] signed_imm_24_in;
   logic [3:0]  dest_in, src1_in, src2_in;
   logic        C_in;

   logic        valid_out;
   logic [3:0]  EXE_CMD_out;
   logic        mem_read_out, mem_write_out, WB_EN_out, B_out, S_out;
   logic [31:0] PC_out, Val_Rn_out, Val_Rm_out;
   logic        imm_out;
   logic [11:0] shift_operand_out;
   logic [23:0] signed_imm_24_out;
   logic [3:0]  dest_out, src1_out, src2_out;
   logic        C_out;
   logic [15:0] bubble_cnt;

   id_stage_reg dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
      .EXE_CMD_in(EXE_CMD_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .WB_EN_in(WB_EN_in), .B_in(B_in), .S_in(S_in), .PC_in(PC_in),
      .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in), .imm_in(imm_in),
      .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
      .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .C_in(C_in),
      .valid_out(valid_out), .EXE_CMD_out(EXE_CMD_out), .mem_read_out(mem_read_out),
      .mem_write_out(mem_write_out), .WB_EN_out(WB_EN_out), .B_out(B_out), .S_out(S_out),
      .PC_out(PC_out), .Val_Rn_out(Val_Rn_out), .Val_Rm_out(Val_Rm_out),
      .imm_out(imm_out), .shift_operand_out(shift_operand_out),
      .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out), .src1_out(src1_out),
      .src2_out(src2_out), .C_out(C_out), .bubble_cnt(bubble_cnt)
   );

   typedef struct packed {
      logic        valid;
      logic [3:0]  cmd;
      logic        mr, mw, wb, b, s, imm, c;
      logic [31:0] pc, rn, rm;
      logic [11:0] sh;
      logic [23:0] si;
      logic [3:0]  dst, s1, s2;
      logic [15:0] cnt;
   } exp_t;

   exp_t mdl;
   exp_t sbq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cmp_all(input exp_t e);
      chk("valid_out",    32'(valid_out),         32'(e.valid));
      chk("EXE_CMD_out",  32'(EXE_CMD_out),       32'(e.cmd));
      chk("mem_read_out", 32'(mem_read_out),      32'(e.mr));
      chk("mem_write_out",32'(mem_write_out),     32'(e.mw));
      chk("WB_EN_out",    32'(WB_EN_out),         32'(e.wb));
      chk("B_out",        32'(B_out),             32'(e.b));
      chk("S_out",        32'(S_out),             32'(e.s));
      chk("PC_out",       PC_out,                 e.pc);
      chk("Val_Rn_out",   Val_Rn_out,             e.rn);
      chk("Val_Rm_out",   Val_Rm_out,             e.rm);
      chk("imm_out",      32'(imm_out),           32'(e.imm));
      chk("shift_out",    32'(shift_operand_out), 32'(e.sh));
      chk("simm24_out",   32'(signed_imm_24_out), 32'(e.si));
      chk("dest_out",     32'(dest_out),          32'(e.dst));
      chk("src1_out",     32'(src1_out),          32'(e.s1));
      chk("src2_out",     32'(src2_out),          32'(e.s2));
      chk("C_out",        32'(C_out),             32'(e.c));
      chk("bubble_cnt",   32'(bubble_cnt),        32'(e.cnt));
   endtask

   function automatic logic [15:0] sat16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Behavioural next state: reset > flush > freeze > load, bubble on invalid load.
   function automatic exp_t nxt(input exp_t m);
      exp_t n;
      n = m;
      if (flush) begin
         n     = '0;
         n.cnt = sat16(m.cnt);
      end else if (!freeze) begin
         n.pc  = PC_in;            n.rn  = Val_Rn_in;        n.rm = Val_Rm_in;
         n.imm = imm_in;           n.sh  = shift_operand_in; n.si = signed_imm_24_in;
         n.dst = dest_in;          n.s1  = src1_in;          n.s2 = src2_in;
         n.c   = C_in;
         n.valid = valid_in;
         if (valid_in) begin
            n.cmd = EXE_CMD_in; n.mr = mem_read_in; n.mw = mem_write_in;
            n.wb  = WB_EN_in;   n.b  = B_in;        n.s  = S_in;
         end else begin
            n.cmd = 4'b0000; n.mr = 1'b0; n.mw = 1'b0;
            n.wb  = 1'b0;    n.b  = 1'b0; n.s  = 1'b0;
            n.cnt = sat16(m.cnt);
         end
      end
      return n;
   endfunction

   // Inputs are set by the caller away from the edge; expectation is queued,
   // then the DUT output is compared 1 time unit after the next rising edge.
   task automatic step(input bit do_chk);
      exp_t e;
      mdl = nxt(mdl);
      sbq.push_back(mdl);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      if (do_chk) cmp_all(e);
   endtask

   task automatic clear_inputs();
      freeze = 0; flush = 0; valid_in = 0; EXE_CMD_in = 4'b0000;
      mem_read_in = 0; mem_write_in = 0; WB_EN_in = 0; B_in = 0; S_in = 0;
      PC_in = '0; Val_Rn_in = '0; Val_Rm_in = '0; imm_in = 0;
      shift_operand_in = '0; signed_imm_24_in = '0;
      dest_in = '0; src1_in = '0; src2_in = '0; C_in = 0;
   endtask

   task automatic randomize_inputs();
      valid_in         = 1'($urandom_range(0, 3) != 0);
      EXE_CMD_in       = 4'($urandom_range(0, 9));
      mem_read_in      = 1'($urandom_range(0, 1));
      mem_write_in     = 1'($urandom_range(0, 1));
      WB_EN_in         = 1'($urandom_range(0, 1));
      B_in             = 1'($urandom_range(0, 1));
      S_in             = 1'($urandom_range(0, 1));
      PC_in            = $urandom;
      Val_Rn_in        = $urandom;
      Val_Rm_in        = $urandom;
      imm_in           = 1'($urandom_range(0, 1));
      shift_operand_in = 12'($urandom);
      signed_imm_24_in = 24'($urandom);
      dest_in          = 4'($urandom);
      src1_in          = 4'($urandom);
      src2_in          = 4'($urandom);
      C_in             = 1'($urandom_range(0, 1));
      freeze           = 1'($urandom_range(0, 3) == 0);
      flush            = 1'($urandom_range(0, 5) == 0);
   endtask

   initial begin
      mdl = '0;
      // Reset with every input high: outputs must clear before any clock edge.
      freeze = 1; flush = 1; valid_in = 1; EXE_CMD_in = 4'hF;
      mem_read_in = 1; mem_write_in = 1; WB_EN_in = 1; B_in = 1; S_in = 1;
      PC_in = '1; Val_Rn_in = '1; Val_Rm_in = '1; imm_in = 1;
      shift_operand_in = '1; signed_imm_24_in = '1;
      dest_in = '1; src1_in = '1; src2_in = '1; C_in = 1;
      rst = 1'b0;
      #1;
      cmp_all(mdl);
      @(posedge clk); #1;
      cmp_all(mdl);
      clear_inputs();
      rst = 1'b1;

      // Plain load of an ADD.
      valid_in = 1; EXE_CMD_in = EXE_ADD; Val_Rn_in = 32'h5; dest_in = 4'd3; WB_EN_in = 1;
      PC_in = 32'h104;
      step(1);

      // Freeze three edges with different inputs, then release.
      freeze = 1; EXE_CMD_in = EXE_SUB; Val_Rn_in = 32'h9; dest_in = 4'd7; mem_write_in = 1;
      repeat (3) step(1);
      freeze = 0;
      step(1);

      // Mixed random traffic including freeze/flush/invalid slots.
      repeat (40) begin
         randomize_inputs();
         step(1);
      end

      // Flush together with freeze: single bubble, no memory write.
      clear_inputs();
      valid_in = 1; EXE_CMD_in = EXE_ORR; mem_write_in = 1; WB_EN_in = 1;
      flush = 1; freeze = 1;
      step(1);

      // Invalid slot with write enables asserted.
      clear_inputs();
      valid_in = 0; WB_EN_in = 1; mem_write_in = 1; EXE_CMD_in = EXE_MOV; Val_Rm_in = 32'hABCD;
      step(1);

      // Reset in the middle of a freeze overrides, then normal loading resumes.
      clear_inputs();
      valid_in = 1; EXE_CMD_in = EXE_EOR; Val_Rn_in = 32'h77; WB_EN_in = 1;
      step(1);
      freeze = 1;
      step(1);
      #2;
      rst = 1'b0;
      #1;
      mdl = '0;
      cmp_all(mdl);
      @(posedge clk); #1;
      rst = 1'b1;
      freeze = 0; EXE_CMD_in = EXE_MVN; Val_Rn_in = 32'h1234;
      step(1);

      // Saturation: 65537 bubble edges, then the counter must stay at FFFF.
      clear_inputs();
      flush = 1;
      repeat (65537) step(0);
      chk("bubble_cnt_sat", 32'(bubble_cnt), 32'hFFFF);
      step(1);
      flush = 0; valid_in = 0;
      step(1);
      valid_in = 1; EXE_CMD_in = EXE_ADC;
      step(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
